cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_pkg.sv | 20 ++
 rtl/cache_mem_arbiter_if.sv | 48 ++++
 rtl/cache_mem_arbiter_line_beat_counter.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 115 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory refill arbiter: FSM encoding,
// requester identity and the line-size legality rule.
package cache_mem_arbiter_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] I_RD = 3'd1;
    localparam logic [2:0] D_RD = 3'd2;
    localparam logic [2:0] D_WR = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    function automatic bit line_words_legal(input int unsigned n);
        return (n >= 2) && (n <= 32) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-side, D-side and memory-side signals of the arbiter.
// master is the arbiter's view; slave is the view of the caches and memory.
interface cache_mem_arbiter_if #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [IDX_W-1:0]  d_widx;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output i_rvalid, i_rdata, i_done,
        output d_widx, d_rvalid, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  i_rvalid, i_rdata, i_done,
        input  d_widx, d_rvalid, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter_line_beat_counter.sv
// Beat counter for one cache line: counts 0..LINE_WORDS, cleared between bursts.
module line_beat_counter #(
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = $clog2(LINE_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; no latch can form.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is asynchronous active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter granting whole-line memory bursts to the I-cache refill
// path or the D-cache refill/write-back path.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_WORDS);

    if (!line_words_legal(LINE_WORDS)) begin : g_bad_line_words
        $error("LINE_WORDS must be a power of two from 2 to 32");
    end

    logic [2:0]        state_q, state_d;
    side_e             grant_q, grant_d;
    side_e             last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [CNT_W-1:0]  issue_cnt, ret_cnt;
    logic              cnt_clr, issue_inc, ret_inc;
    logic              in_read, in_burst, issue_active;

    assign in_read      = (state_q == I_RD) || (state_q == D_RD);
    assign in_burst     = in_read || (state_q == D_WR);
    assign issue_active = in_burst && (issue_cnt != FULL);
    assign issue_inc    = issue_active && bus.mem_ready;
    // Returns outside a read burst, or beyond a full line, are dropped.
    assign ret_inc      = in_read && bus.mem_rvalid && (ret_cnt != FULL);
    assign cnt_clr      = (state_q == IDLE);

    line_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (issue_inc),
        .count (issue_cnt)
    );

    line_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (ret_inc),
        .count (ret_cnt)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || (last_q == SIDE_I))) begin
                    grant_d = SIDE_D;
                    state_d = bus.d_we ? D_WR : D_RD;
                    base_d  = {bus.d_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                end else if (bus.i_req) begin
                    grant_d = SIDE_I;
                    state_d = I_RD;
                    base_d  = {bus.i_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                end
            end
            I_RD, D_RD: begin
                if (ret_cnt + CNT_W'(ret_inc) == FULL) state_d = DONE;
            end
            D_WR: begin
                if (issue_cnt + CNT_W'(issue_inc) == FULL) state_d = DONE;
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= SIDE_I;
            last_q  <= SIDE_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    assign bus.mem_req   = issue_active;
    assign bus.mem_we    = (state_q == D_WR);
    assign bus.mem_addr  = issue_active ? base_q + (ADDR_W'(issue_cnt) << 2) : '0;
    assign bus.mem_wdata = (state_q == D_WR) ? bus.d_wdata : 32'd0;
    assign bus.d_widx    = (state_q == D_WR) ? issue_cnt[IDX_W-1:0] : '0;

    assign bus.i_rvalid  = (state_q == I_RD) && ret_inc;
    assign bus.i_rdata   = (state_q == I_RD) ? bus.mem_rdata : 32'd0;
    assign bus.d_rvalid  = (state_q == D_RD) && ret_inc;
    assign bus.d_rdata   = (state_q == D_RD) ? bus.mem_rdata : 32'd0;

    assign bus.i_done    = (state_q == DONE) && (grant_q == SIDE_I);
    assign bus.d_done    = (state_q == DONE) && (grant_q == SIDE_D);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a memory model with random latency and
// back-pressure, transaction-level expectations, and a decoupled monitor.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int LW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.LINE_WORDS(LW), .ADDR_W(AW)) bus ();

    cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          idx;
    } beat_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    beat_t       beats_q[$];
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    int          done_q[$];
    ret_t        pend_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_due = 0;
    int last_evt[2];
    int i_rv_cnt = 0;
    int last_side = 0;

    int ready_mode = 0;
    int lat_min = 2;
    int lat_max = 2;
    bit spur_en = 1'b0;
    logic [31:0] wb_line[LW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: drives ready, in-order returns and optional spurious rvalid.
    always @(negedge clk) begin
        bus.d_wdata = wb_line[bus.d_widx];
        case (ready_mode)
            0:       bus.mem_ready = 1'b1;
            1:       bus.mem_ready = ~bus.mem_ready;
            default: bus.mem_ready = 1'($urandom_range(0, 1));
        endcase
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = pend_q[0].data;
            void'(pend_q.pop_front());
        end else if (spur_en && i_exp_q.size() == 0 && d_exp_q.size() == 0 &&
                     $urandom_range(0, 2) == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'd0;
        end
    end

    task automatic check_done(input int side);
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
            check("done_side", side, done_q.pop_front());
            check("done_timing", cyc, last_evt[side] + 1);
        end
    endtask

    // Monitor: compares every presented beat, return and done against the queues.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.mem_req) begin
                check("beat_expected", beats_q.size() != 0, 1);
                if (beats_q.size() != 0) begin
                    check("mem_addr", bus.mem_addr, beats_q[0].addr);
                    check("mem_we", bus.mem_we, beats_q[0].we);
                    if (beats_q[0].we) begin
                        check("d_widx", bus.d_widx, beats_q[0].idx);
                        check("mem_wdata", bus.mem_wdata, beats_q[0].wdata);
                    end
                    if (bus.mem_ready) begin
                        if (!beats_q[0].we) begin
                            int d;
                            d = cyc + $urandom_range(lat_min, lat_max);
                            if (d <= last_due) d = last_due + 1;
                            last_due = d;
                            pend_q.push_back('{d, mem_data(bus.mem_addr)});
                        end else if (beats_q[0].idx == LW - 1) begin
                            last_evt[1] = cyc;
                        end
                        void'(beats_q.pop_front());
                    end
                end
            end
            if (bus.i_rvalid) begin
                i_rv_cnt++;
                check("i_rvalid_expected", i_exp_q.size() != 0, 1);
                if (i_exp_q.size() != 0) check("i_rdata", bus.i_rdata, i_exp_q.pop_front());
                if (i_exp_q.size() == 0) last_evt[0] = cyc;
            end
            if (bus.d_rvalid) begin
                check("d_rvalid_expected", d_exp_q.size() != 0, 1);
                if (d_exp_q.size() != 0) check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
                if (d_exp_q.size() == 0) last_evt[1] = cyc;
            end
            if (bus.i_done) check_done(0);
            if (bus.d_done) check_done(1);
        end
    end

    // Expected line transfer: base has the byte offset within the line cleared.
    task automatic expect_txn(input int side, input logic we, input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~(32'(LW * 4) - 32'd1);
        for (int k = 0; k < LW; k++) begin
            beats_q.push_back('{base + 32'(4 * k), we, we ? wb_line[k] : 32'd0, k});
            if (!we) begin
                if (side == 0) i_exp_q.push_back(mem_data(base + 32'(4 * k)));
                else           d_exp_q.push_back(mem_data(base + 32'(4 * k)));
            end
        end
        done_q.push_back(side);
    endtask

    task automatic flush_all();
        beats_q.delete();
        i_exp_q.delete();
        d_exp_q.delete();
        done_q.delete();
        pend_q.delete();
        last_due = 0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctl"}, {bus.mem_req, bus.mem_we, bus.i_rvalid, bus.d_rvalid,
                               bus.i_done, bus.d_done}, 0);
        check({name, "_addr"}, bus.mem_addr, 0);
        check({name, "_wdata"}, bus.mem_wdata, 0);
        check({name, "_widx"}, bus.d_widx, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_quiet("reset");
        flush_all();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        last_side = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic req_i(input logic [31:0] addr);
        bus.i_addr = addr;
        bus.i_req  = 1'b1;
    endtask

    task automatic req_d(input logic we, input logic [31:0] addr);
        bus.d_we   = we;
        bus.d_addr = addr;
        bus.d_req  = 1'b1;
    endtask

    // Clients hold requests until their done pulse; bounded wait for all expected dones.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((done_q.size() != 0 || bus.i_req || bus.d_req) && n < 3000) begin
            @(negedge clk);
            #2;
            if (bus.i_done) bus.i_req = 1'b0;
            if (bus.d_done) bus.d_req = 1'b0;
            n++;
        end
        check({name, "_timeout"}, n < 3000, 1);
        if (n >= 3000) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            flush_all();
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic single(input int side, input logic we, input logic [31:0] addr);
        expect_txn(side, we, addr);
        last_side = side;
        @(posedge clk);
        #2;
        if (side == 0) req_i(addr);
        else           req_d(we, addr);
    endtask

    task automatic tie(input logic [31:0] ia, input logic dwe, input logic [31:0] da);
        if (last_side == 0) begin
            expect_txn(1, dwe, da);
            expect_txn(0, 1'b0, ia);
            last_side = 0;
        end else begin
            expect_txn(0, 1'b0, ia);
            expect_txn(1, dwe, da);
            last_side = 1;
        end
        @(posedge clk);
        #2;
        req_i(ia);
        req_d(dwe, da);
    endtask

    initial begin
        int n;
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus.mem_ready = 1'b0;  bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        last_evt[0] = 0;
        last_evt[1] = 0;
        for (int k = 0; k < LW; k++) wb_line[k] = $urandom;

        do_reset();

        // I-only refill, ready always high, latency 2.
        single(0, 1'b0, 32'h1000_0014);
        wait_done("i_only");

        // D write-back with mem_ready toggling and stray rvalid pulses.
        ready_mode = 1;
        spur_en = 1'b1;
        single(1, 1'b1, 32'h2000_0020);
        wait_done("d_wb");

        // Round-robin: D wins the first tie after reset, I the tie after a D grant.
        ready_mode = 0;
        lat_min = 1;
        lat_max = 3;
        do_reset();
        tie(32'h3000_0104, 1'b0, 32'h4000_0208);
        wait_done("tie1");
        single(1, 1'b0, 32'h4100_0000);
        wait_done("d_between");
        tie(32'h3100_0040, 1'b1, 32'h4200_0080);
        wait_done("tie2");

        // Latency 1: the final return follows the final issue directly.
        lat_min = 1;
        lat_max = 1;
        single(1, 1'b0, 32'h5000_003C);
        wait_done("lat1");

        // Requester drops its request mid-burst; burst still completes.
        lat_max = 3;
        expect_txn(0, 1'b0, 32'h6000_0010);
        last_side = 0;
        @(posedge clk);
        #2 req_i(32'h6000_0010);
        repeat (3) @(posedge clk);
        #2 bus.i_req = 1'b0;
        wait_done("drop_req");

        // Reset mid-burst after three returns; the next burst restarts at beat 0.
        lat_min = 1;
        lat_max = 2;
        i_rv_cnt = 0;
        single(0, 1'b0, 32'h7000_0020);
        n = 0;
        while (i_rv_cnt < 3 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("mid_reset_wait", n < 200, 1);
        do_reset();
        repeat (3) @(posedge clk);
        #2 check_quiet("post_reset");
        single(0, 1'b0, 32'h7000_0020);
        wait_done("after_reset");

        // Randomized traffic: back-pressure, latency, stray returns and ties.
        for (int t = 0; t < 16; t++) begin
            int kind;
            ready_mode = $urandom_range(0, 2);
            lat_min = 1;
            lat_max = $urandom_range(1, 5);
            spur_en = 1'($urandom_range(0, 1));
            for (int k = 0; k < LW; k++) wb_line[k] = $urandom;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       single(0, 1'b0, $urandom);
                1:       single(1, 1'b0, $urandom);
                2:       single(1, 1'b1, $urandom);
                default: tie($urandom, 1'($urandom_range(0, 1)), $urandom);
            endcase
            wait_done("random");
        end

        check("queues_drained", beats_q.size() + i_exp_q.size() + d_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
